// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: serial line in, received byte and status strobes out
interface uart_rx_frame_if;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       busy_o;
  logic       frame_err_o;
  logic       parity_err_o;
  modport master(input rx_i, output data_o, valid_o, busy_o, frame_err_o, parity_err_o);
  modport slave(output rx_i, input data_o, valid_o, busy_o, frame_err_o, parity_err_o);
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8N1 UART receiver, 8E1 when UART_RX_PARITY_EN is defined
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 868
) (
  input logic clk,
  input logic rst,
  uart_rx_frame_if.master bus
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] HALF_M1 = W'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BRK
  } state_t;
  state_t state;
  logic [2:0] sync;
  logic [W-1:0] clk_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg, data;
  logic valid, busy, ferr;
  logic line, fall;
  assign line = sync[1];
  assign fall = sync[2] & ~sync[1];
  assign bus.data_o = data;
  assign bus.valid_o = valid;
  assign bus.busy_o = busy;
  assign bus.frame_err_o = ferr;
`ifdef UART_RX_PARITY_EN
  logic par_bad, perr;
  assign bus.parity_err_o = perr;
`else
  assign bus.parity_err_o = 1'b0;
`endif
  // synchronizer, edge detect and frame FSM with registered strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 3'b111;
      state <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      data <= '0;
      valid <= 1'b0;
      busy <= 1'b0;
      ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
      perr <= 1'b0;
`endif
    end else begin
      sync <= {sync[1:0], bus.rx_i};
      clk_cnt <= clk_cnt + 1'b1;
      valid <= 1'b0;
      ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr <= 1'b0;
`endif
      case (state)
        IDLE: if (fall) begin
          clk_cnt <= '0;
          busy <= 1'b1;
          state <= START;
        end
        START: if (clk_cnt == HALF_M1) begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          busy <= ~line;
          state <= line ? IDLE : DATA;
        end
        DATA: if (clk_cnt == LAST) begin
          clk_cnt <= '0;
          shreg <= {line, shreg[7:1]};
          bit_cnt <= bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt == 3'd7) state <= PARITY;
`else
          if (bit_cnt == 3'd7) state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (clk_cnt == LAST) begin
          clk_cnt <= '0;
          par_bad <= line ^ (^shreg);
          state <= STOP;
        end
`endif
        STOP: if (clk_cnt == LAST) begin
          clk_cnt <= '0;
          busy <= ~line;
          ferr <= ~line;
          state <= line ? IDLE : BRK;
`ifdef UART_RX_PARITY_EN
          valid <= line & ~par_bad;
          perr <= line & par_bad;
          if (line & ~par_bad) data <= shreg;
`else
          valid <= line;
          if (line) data <= shreg;
`endif
        end
        BRK: if (line) begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: table, hand-written and random frames against a frame-level model
module tb_uart_rx_frame;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  typedef struct {
    logic [7:0] d;
    logic stop;
    logic par_ok;
    logic [7:0] edata;
    int ev;
    int ef;
    int ep;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_frame_if bus();
  uart_rx_frame #(.CLKS_PER_BIT(CPB)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int tests = 0, fails = 0, cyc = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0, n_busy = 0, last_valid = -1;
  logic [7:0] got[$];
  logic [7:0] model_data;
  vec_t vt[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst) begin
    if (bus.valid_o) begin
      n_valid++;
      last_valid = cyc;
      got.push_back(bus.data_o);
    end
    if (bus.frame_err_o) n_ferr++;
    if (bus.parity_err_o) n_perr++;
    if (bus.busy_o) n_busy++;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic bit_out(input logic b);
    bus.rx_i = b;
    repeat (CPB) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input logic par_ok);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    if (PAR) bit_out(par_ok ? ^d : ~^d);
    bit_out(stop);
  endtask
  task automatic run_frame(input string name, input logic [7:0] d, input logic stop,
                           input logic par_ok, input int hold, input logic [7:0] edata,
                           input int ev, input int ef, input int ep);
    int v0, f0, p0;
    v0 = n_valid;
    f0 = n_ferr;
    p0 = n_perr;
    send(d, stop, par_ok);
    if (!stop) repeat (hold) @(negedge clk);
    bus.rx_i = 1'b1;
    repeat (20) @(negedge clk);
    check({name, " valid"}, n_valid - v0, ev);
    check({name, " frame_err"}, n_ferr - f0, ef);
    check({name, " parity_err"}, n_perr - p0, ep);
    check({name, " data"}, bus.data_o, edata);
    check({name, " idle"}, bus.busy_o, 0);
    if (ev == 1) check({name, " byte"}, got[$], d);
  endtask
  initial begin
    int t0, v0, f0, p0;
    bus.rx_i = 1'b1;
    repeat (3) @(negedge clk);
    check("reset data", bus.data_o, 0);
    check("reset valid", bus.valid_o, 0);
    check("reset busy", bus.busy_o, 0);
    check("reset frame_err", bus.frame_err_o, 0);
    check("reset parity_err", bus.parity_err_o, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    t0 = cyc;
    run_frame("a5", 8'hA5, 1'b1, 1'b1, 0, 8'hA5, 1, 0, 0);
    check("a5 timing", last_valid, t0 + 3 + CPB / 2 + 9 * CPB + (PAR ? CPB : 0));
    vt.push_back('{8'h3C, 1'b0, 1'b1, 8'hA5, 0, 1, 0});
    vt.push_back('{8'h81, 1'b1, 1'b1, 8'h81, 1, 0, 0});
    vt.push_back('{8'h5A, 1'b1, 1'b1, 8'h5A, 1, 0, 0});
    vt.push_back('{8'hFF, 1'b0, 1'b1, 8'h5A, 0, 1, 0});
    vt.push_back('{8'h00, 1'b1, 1'b1, 8'h00, 1, 0, 0});
`ifdef UART_RX_PARITY_EN
    vt.push_back('{8'h07, 1'b1, 1'b1, 8'h07, 1, 0, 0});
    vt.push_back('{8'h07, 1'b1, 1'b0, 8'h07, 0, 0, 1});
    vt.push_back('{8'h12, 1'b1, 1'b0, 8'h07, 0, 0, 1});
    vt.push_back('{8'h12, 1'b0, 1'b0, 8'h07, 0, 1, 0});
`endif
    foreach (vt[i]) run_frame($sformatf("vec%0d", i), vt[i].d, vt[i].stop, vt[i].par_ok, 40,
                              vt[i].edata, vt[i].ev, vt[i].ef, vt[i].ep);
    v0 = n_valid;
    send(8'h00, 1'b1, 1'b1);
    send(8'hFF, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b count", n_valid - v0, 2);
    check("b2b first", got[$-1], 8'h00);
    check("b2b second", got[$], 8'hFF);
    check("b2b data", bus.data_o, 8'hFF);
    v0 = n_valid;
    f0 = n_ferr;
    p0 = n_perr;
    n_busy = 0;
    bus.rx_i = 1'b0;
    repeat (4) @(negedge clk);
    bus.rx_i = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch busy cycles", n_busy, 8);
    check("glitch pulses", (n_valid - v0) + (n_ferr - f0) + (n_perr - p0), 0);
    v0 = n_valid;
    f0 = n_ferr;
    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(8'h5A >> i);
    bus.rx_i = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst busy", bus.busy_o, 0);
    check("midrst data", bus.data_o, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst no pulse", (n_valid - v0) + (n_ferr - f0), 0);
    run_frame("after rst", 8'h81, 1'b1, 1'b1, 0, 8'h81, 1, 0, 0);
    model_data = 8'h81;
    for (int i = 0; i < 24; i++) begin
      logic [7:0] d;
      logic stop, par_ok, good;
      d = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      par_ok = PAR ? ($urandom_range(0, 3) != 0) : 1'b1;
      good = stop && par_ok;
      if (good) model_data = d;
      run_frame($sformatf("rnd%0d", i), d, stop, par_ok, $urandom_range(20, 40), model_data,
                good, !stop, stop && !par_ok);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Standalone UART receiver. Recovers 8-bit frames from an asynchronous serial line: 8N1, or 8E1 when parity is compiled in. Sits between the board's serial input pin and the top-level control logic. It delivers each byte as a one-cycle `valid_o` strobe and reports framing and parity errors. It is the receiving end of the frames that `uart_transmit` produces.

## Interface
- `CLKS_PER_BIT`, default 868 — clk cycles per bit (100 MHz / 115200 baud); must be ≥ 4
- `clk` input 1 — system clock; all logic on its rising edge
- `rst` input 1 — synchronous, active-high reset
- `rx_i` input 1 — asynchronous serial line, idle high
- `data_o` output 8 — last good byte received, LSB = first data bit
- `valid_o` output 1 — one-cycle pulse: `data_o` updated with a good frame
- `busy_o` output 1 — high from start-bit detection until return to IDLE
- `frame_err_o` output 1 — one-cycle pulse: stop bit sampled low
- `parity_err_o` output 1 — one-cycle pulse: parity mismatch (tied 0 without the parity macro)

## Operation
- `rx_i` passes through a 2-FF synchronizer (preset high on reset). A third register on the synchronized value forms the falling-edge detect.
- Bit counter `bit_cnt` counts 0..7. Cycle counter `clk_cnt` is wide enough for `CLKS_PER_BIT-1`. `HALF = CLKS_PER_BIT/2` (integer divide).
- States:
  - **IDLE:** `busy_o = 0`. On a synchronized falling edge, clear `clk_cnt` and go to START.
  - **START:** when `clk_cnt == HALF-1`, sample the line:
    - low → clear `clk_cnt` and `bit_cnt`, go to DATA;
    - high → glitch; return to IDLE with no error flag.
  - **DATA:** when `clk_cnt == CLKS_PER_BIT-1`, sample the line into shift register bit [7] and shift right (LSB first).
    - After the 8th sample, go to PARITY if enabled, else STOP.
  - **PARITY** (macro only): sample one bit period later and compare with the XOR of the 8 data bits (even parity). Store the mismatch flag.
  - **STOP:** sample one bit period later.
    - High, no parity mismatch → load `data_o`, pulse `valid_o`, go to IDLE.
    - High, parity mismatch → pulse `parity_err_o`, leave `data_o` unchanged, go to IDLE.
    - Low → pulse `frame_err_o`, leave `data_o` unchanged, go to BREAK.
  - **BREAK:** wait for the synchronized line to be high, then go to IDLE. This prevents a held-low line (break) from retriggering.
- All error and valid outputs are mutually exclusive within a frame.
- A falling edge during STOP→IDLE is honored the cycle after entering IDLE. Back-to-back frames with a single stop bit must be received without loss.

## Timing
- Reset values: `data_o = 8'h00`, `valid_o = 0`, `busy_o = 0`, `frame_err_o = 0`, `parity_err_o = 0`, state IDLE, synchronizer = 1.
- `rst` mid-frame returns to IDLE on the next edge. The partial frame is discarded and no pulses are emitted.
- Edge detect (cycle E) occurs 3 clk after `rx_i` falls.
- Sample points, relative to E:
  - start bit: `E + HALF`;
  - data bit n: `E + HALF + (n+1)·CLKS_PER_BIT`;
  - stop bit: `E + HALF + 9·CLKS_PER_BIT` (+1 bit period with parity).
- `valid_o` / `frame_err_o` / `parity_err_o` assert in the cycle after the stop sample, for exactly 1 cycle.
- `data_o` is stable from the `valid_o` cycle until the next `valid_o`.
- `busy_o` goes high the cycle after E and low in the cycle the pulse asserts.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is 8E1 and the PARITY state exists; `parity_err_o` is live.
- Not defined: frame is 8N1, the PARITY state is omitted, and `parity_err_o` is tied to 0.

## Test plan
All scenarios use `CLKS_PER_BIT = 16` and ideal stimulus.
- Reset, then send 0xA5 (8N1) → `data_o = 0xA5`, one `valid_o` pulse at E+8+144+1, no error pulses.
- Send 0x00 then 0xFF back-to-back with one stop bit each → two `valid_o` pulses, `data_o` 0x00 then 0xFF.
- 4-cycle low glitch on idle line → no pulses; `busy_o` high for 8 cycles, then IDLE.
- Send 0x3C with stop bit low, line held low for 40 more cycles → `frame_err_o` pulse, `data_o` keeps its previous value, no retrigger until the line rises.
- Assert `rst` during data bit 4 of 0x5A, then send 0x81 → only 0x81 is reported, `valid_o` once.
- With `UART_RX_PARITY_EN`:
  - send 0x07 with parity bit 1 → `valid_o`, `data_o = 0x07`;
  - send 0x07 with parity bit 0 → `parity_err_o` pulse, `data_o` unchanged.
